sonar_ping_sequencer: RTL and testbench

//  Sequences one sonar measurement ("ping"): transmits a burst, blanks the receiver, then

---
 rtl/sonar_ping_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_sonar_ping_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sonar_ping_sequencer.sv
// sonar_ping_sequencer
// Sequences one sonar ping: transmit burst (TX), receiver blanking (BLANK),
// then an echo listen window (LISTEN), reporting time-of-flight and an IRQ.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      begin a ping (IDLE only) / return to IDLE immediately
//   half_period       tx half-period in clk cycles (0 behaves as 1)
//   n_pulses          tx burst length in full periods (0 = no burst)
//   blank_len         blanking cycles after the burst
//   listen_len        listen window cycles (0 = immediate timeout)
//   echo_in           threshold comparator output
//   irq_ack           clears done/irq
//   tx_out, ce_out    transmitter drive / receive datapath clock enable
//   busy, done, irq   status; irq mirrors done
//   echo_valid, tof   echo seen flag and time-of-flight (all-ones on timeout)
//   state_o           IDLE=0, TX=1, BLANK=2, LISTEN=3
module sonar_ping_sequencer #(
    parameter int CNT_W   = 32,
    parameter int PULSE_W = 8,
    parameter int HP_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [HP_W-1:0]    half_period,
    input  logic [PULSE_W-1:0] n_pulses,
    input  logic [CNT_W-1:0]   blank_len,
    input  logic [CNT_W-1:0]   listen_len,
    input  logic               echo_in,
    input  logic               irq_ack,
    output logic               tx_out,
    output logic               ce_out,
    output logic               busy,
    output logic               done,
    output logic               irq,
    output logic               echo_valid,
    output logic [CNT_W-1:0]   tof,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TX     = 2'd1,
        BLANK  = 2'd2,
        LISTEN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [HP_W-1:0]    HP_ZERO  = {HP_W{1'b0}};
    localparam logic [HP_W-1:0]    HP_ONE   = {{(HP_W-1){1'b0}}, 1'b1};
    localparam logic [PULSE_W-1:0] NP_ZERO  = {PULSE_W{1'b0}};
    localparam logic [PULSE_W:0]   HALF_ZERO = {(PULSE_W+1){1'b0}};
    localparam logic [PULSE_W:0]   HALF_ONE  = {{PULSE_W{1'b0}}, 1'b1};

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [CNT_W-1:0]     len_cnt_r, len_cnt_s;
    logic [HP_W-1:0]      hp_cnt_r, hp_cnt_s;
    logic [PULSE_W:0]     half_cnt_r, half_cnt_s;
    logic [HP_W-1:0]      hp_cfg_r, hp_cfg_s;
    logic [PULSE_W-1:0]   np_cfg_r, np_cfg_s;
    logic [CNT_W-1:0]     blank_cfg_r, blank_cfg_s;
    logic [CNT_W-1:0]     listen_cfg_r, listen_cfg_s;
    logic                 tx_r, tx_s;
    logic                 ce_r, ce_s;
    logic                 done_r, done_s;
    logic                 ev_r, ev_s;
    logic [CNT_W-1:0]     tof_r, tof_s;
    logic                 echo_q_r;
    logic                 rise_s;
    logic [HP_W-1:0]      hp_last_s;
    logic [PULSE_W:0]     half_last_s;

    // Next-state, counters and output-register values for the ping sequence.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        len_cnt_s    = len_cnt_r;
        hp_cnt_s     = hp_cnt_r;
        half_cnt_s   = half_cnt_r;
        hp_cfg_s     = hp_cfg_r;
        np_cfg_s     = np_cfg_r;
        blank_cfg_s  = blank_cfg_r;
        listen_cfg_s = listen_cfg_r;
        tx_s         = tx_r;
        ev_s         = ev_r;
        tof_s        = tof_r;
        // echo_q follows echo_in in every state, so a level already high on
        // LISTEN entry is not mistaken for a rising edge.
        rise_s       = echo_in & ~echo_q_r;
        hp_last_s    = (hp_cfg_r == HP_ZERO) ? HP_ZERO : (hp_cfg_r - HP_ONE);
        half_last_s  = {np_cfg_r, 1'b0} - HALF_ONE;

        if (irq_ack) begin
            done_s = 1'b0;
        end else begin
            done_s = done_r;
        end

        if (state_r != IDLE) begin
            cnt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        end else begin
            cnt_s = cnt_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    hp_cfg_s     = half_period;
                    np_cfg_s     = n_pulses;
                    blank_cfg_s  = blank_len;
                    listen_cfg_s = listen_len;
                    done_s       = 1'b0;
                    ev_s         = 1'b0;
                    cnt_s        = CNT_ZERO;
                    len_cnt_s    = CNT_ZERO;
                    hp_cnt_s     = HP_ZERO;
                    half_cnt_s   = HALF_ZERO;
                    if (n_pulses == NP_ZERO) begin
                        tx_s    = 1'b0;
                        state_s = (blank_len == CNT_ZERO) ? LISTEN : BLANK;
                    end else begin
                        tx_s    = 1'b1;
                        state_s = TX;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            TX: begin
                if (hp_cnt_r == hp_last_s) begin
                    hp_cnt_s   = HP_ZERO;
                    half_cnt_s = half_cnt_r + HALF_ONE;
                    if (half_cnt_r == half_last_s) begin
                        tx_s      = 1'b0;
                        len_cnt_s = CNT_ZERO;
                        state_s   = (blank_cfg_r == CNT_ZERO) ? LISTEN : BLANK;
                    end else begin
                        tx_s = ~tx_r;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r + HP_ONE;
                end
            end
            BLANK: begin
                if (len_cnt_r == (blank_cfg_r - CNT_ONE)) begin
                    len_cnt_s = CNT_ZERO;
                    state_s   = LISTEN;
                end else begin
                    len_cnt_s = len_cnt_r + CNT_ONE;
                end
            end
            LISTEN: begin
                if (listen_cfg_r == CNT_ZERO) begin
                    tof_s   = CNT_MAX;
                    ev_s    = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (rise_s) begin
                    // An edge on the final window cycle still counts as an echo.
                    tof_s   = cnt_r;
                    ev_s    = 1'b1;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (len_cnt_r == (listen_cfg_r - CNT_ONE)) begin
                    tof_s   = CNT_MAX;
                    ev_s    = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    len_cnt_s = len_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                tx_s    = 1'b0;
            end
        endcase

        // Abort overrides everything, including a same-cycle start or completion.
        if (abort) begin
            state_s      = IDLE;
            tx_s         = 1'b0;
            done_s       = irq_ack ? 1'b0 : done_r;
            ev_s         = ev_r;
            tof_s        = tof_r;
            hp_cfg_s     = hp_cfg_r;
            np_cfg_s     = np_cfg_r;
            blank_cfg_s  = blank_cfg_r;
            listen_cfg_s = listen_cfg_r;
        end else begin
            state_s = state_s;
        end

        ce_s = (state_s == BLANK) || (state_s == LISTEN);
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            len_cnt_r    <= CNT_ZERO;
            hp_cnt_r     <= HP_ZERO;
            half_cnt_r   <= HALF_ZERO;
            hp_cfg_r     <= HP_ZERO;
            np_cfg_r     <= NP_ZERO;
            blank_cfg_r  <= CNT_ZERO;
            listen_cfg_r <= CNT_ZERO;
            tx_r         <= 1'b0;
            ce_r         <= 1'b0;
            done_r       <= 1'b0;
            ev_r         <= 1'b0;
            tof_r        <= CNT_ZERO;
            echo_q_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            len_cnt_r    <= len_cnt_s;
            hp_cnt_r     <= hp_cnt_s;
            half_cnt_r   <= half_cnt_s;
            hp_cfg_r     <= hp_cfg_s;
            np_cfg_r     <= np_cfg_s;
            blank_cfg_r  <= blank_cfg_s;
            listen_cfg_r <= listen_cfg_s;
            tx_r         <= tx_s;
            ce_r         <= ce_s;
            done_r       <= done_s;
            ev_r         <= ev_s;
            tof_r        <= tof_s;
            echo_q_r     <= echo_in;
        end
    end

    assign tx_out     = tx_r;
    assign ce_out     = ce_r;
    assign busy       = (state_r != IDLE);
    assign done       = done_r;
    assign irq        = done_r;
    assign echo_valid = ev_r;
    assign tof        = tof_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Directed testbench for sonar_ping_sequencer.
module tb_sonar_ping_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] half_period;
    logic [7:0]  n_pulses;
    logic [31:0] blank_len;
    logic [31:0] listen_len;
    logic        echo_in;
    logic        irq_ack;
    logic        tx_out;
    logic        ce_out;
    logic        busy;
    logic        done;
    logic        irq;
    logic        echo_valid;
    logic [31:0] tof;
    logic [1:0]  state_o;

    int n_checks;
    int n_fail;

    sonar_ping_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .half_period(half_period), .n_pulses(n_pulses),
        .blank_len(blank_len), .listen_len(listen_len),
        .echo_in(echo_in), .irq_ack(irq_ack),
        .tx_out(tx_out), .ce_out(ce_out), .busy(busy), .done(done),
        .irq(irq), .echo_valid(echo_valid), .tof(tof), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; echo_in = 1'b0; irq_ack = 1'b0;
        half_period = 16'd2; n_pulses = 8'd3; blank_len = 32'd10; listen_len = 32'd50;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_flags", {26'd0, tx_out, ce_out, busy, done, irq, echo_valid}, 32'd0);
        check("rst_tof", tof, 32'd0);

        // 1: echo at counter 30; config changed mid-ping must not matter
        pulse_start();                      // now at counter 0
        half_period = 16'd5;
        check("t1_state0", {30'd0, state_o}, 32'd1);
        check("t1_busy0", {31'd0, busy}, 32'd1);
        check("t1_ce0", {31'd0, ce_out}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            check("t1_tx", {31'd0, tx_out}, ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
            step(1);
        end
        check("t1_blank_state", {30'd0, state_o}, 32'd2);
        check("t1_blank_ce", {31'd0, ce_out}, 32'd1);
        check("t1_blank_tx", {31'd0, tx_out}, 32'd0);
        step(10);                           // counter 22
        check("t1_listen_state", {30'd0, state_o}, 32'd3);
        step(8);                            // counter 30
        echo_in = 1'b1;
        step(1);
        check("t1_idle", {30'd0, state_o}, 32'd0);
        check("t1_tof", tof, 32'd30);
        check("t1_ev", {31'd0, echo_valid}, 32'd1);
        check("t1_done_irq", {30'd0, done, irq}, 32'd3);
        check("t1_ce_idle", {31'd0, ce_out}, 32'd0);
        echo_in = 1'b0;
        half_period = 16'd2;
        ack();
        check("t1_ack", {30'd0, done, irq}, 32'd0);

        // 2: timeout, window ends at counter 71
        pulse_start();
        step(71);
        check("t2_last_listen", {30'd0, state_o}, 32'd3);
        step(1);
        check("t2_idle", {30'd0, state_o}, 32'd0);
        check("t2_tof", tof, 32'hFFFF_FFFF);
        check("t2_ev", {31'd0, echo_valid}, 32'd0);
        check("t2_irq", {31'd0, irq}, 32'd1);
        ack();

        // 3: echo held high into LISTEN, falls at 25, rises at 40
        pulse_start();
        step(15);
        echo_in = 1'b1;
        step(7);                            // counter 22
        check("t3_listen", {30'd0, state_o}, 32'd3);
        step(3);                            // counter 25
        check("t3_no_false", {30'd0, state_o}, 32'd3);
        echo_in = 1'b0;
        step(15);                           // counter 40
        echo_in = 1'b1;
        step(1);
        check("t3_tof", tof, 32'd40);
        check("t3_ev_done", {30'd0, echo_valid, done}, 32'd3);
        echo_in = 1'b0;
        ack();

        // 4: abort during TX at counter 5, then a normal ping
        pulse_start();
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_idle", {30'd0, state_o}, 32'd0);
        check("t4_tx_busy_irq", {29'd0, tx_out, busy, irq}, 32'd0);
        check("t4_tof_held", tof, 32'd40);
        half_period = 16'd1; n_pulses = 8'd1; blank_len = 32'd0; listen_len = 32'd3;
        pulse_start();                      // counter 0
        check("t4_ev_cleared", {31'd0, echo_valid}, 32'd0);
        check("t4_tx0", {31'd0, tx_out}, 32'd1);
        step(1);
        check("t4_tx1", {30'd0, tx_out, state_o[0]}, 32'd1);
        step(1);                            // counter 2
        check("t4_listen", {29'd0, ce_out, state_o}, 32'd7);
        step(1);                            // counter 3
        echo_in = 1'b1;
        step(1);
        check("t4_tof", tof, 32'd3);
        check("t4_done", {30'd0, done, echo_valid}, 32'd3);
        echo_in = 1'b0;
        ack();

        // 5: no burst, no blank, zero window
        n_pulses = 8'd0; blank_len = 32'd0; listen_len = 32'd0;
        pulse_start();
        check("t5_state", {29'd0, tx_out, state_o}, 32'd3);
        step(1);
        check("t5_idle", {30'd0, state_o}, 32'd0);
        check("t5_done", {30'd0, done, echo_valid}, 32'd2);
        check("t5_tof", tof, 32'hFFFF_FFFF);
        ack();

        // 6: start ignored in LISTEN; echo on final cycle with same-cycle ack
        half_period = 16'd1; n_pulses = 8'd1; blank_len = 32'd2; listen_len = 32'd4;
        pulse_start();
        step(5);                            // counter 5
        start = 1'b1;
        step(1);                            // counter 6
        start = 1'b0;
        check("t6_start_ignored", {30'd0, state_o}, 32'd3);
        step(1);                            // counter 7
        echo_in = 1'b1;
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        echo_in = 1'b0;
        check("t6_done_wins", {30'd0, done, irq}, 32'd3);
        check("t6_tof", tof, 32'd7);
        check("t6_ev", {31'd0, echo_valid}, 32'd1);
        step(1);
        check("t6_done_sticky", {31'd0, done}, 32'd1);
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("t6_abort_beats_start", {29'd0, busy, state_o}, 32'd0);
        check("t6_abort_keeps", {30'd0, done, echo_valid}, 32'd3);
        ack();
        check("t6_ack", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
